// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type, oversample default and tick divider helper
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;

  // Clocks per oversample tick, rounded to nearest
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int per_tick;
    per_tick = baud * oversample;
    return (clk_freq + per_tick / 2) / per_tick;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line input and received-byte outputs of the UART receiver
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       we;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output data, output we, output frame_err, output busy);
  modport slave  (output rx, input data, input we, input frame_err, input busy);
endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// rtl/uart_rx_baud_tick_gen.sv - one-cycle oversample tick every DIV clocks, restartable
module baud_tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Phase counter; clear realigns the tick phase to a detected start edge
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 oversampling UART receiver with glitch rejection and framing check
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.master bus
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] MID  = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] LAST = OW'(OVERSAMPLE - 1);

  logic          rx_meta, rx_s, rx_s_d;
  state_t        state_q, state_n;
  logic [OW-1:0] os_q, os_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    sh_q, sh_n;
  logic [7:0]    data_q, data_n;
  logic          we_q, we_n;
  logic          ferr_q, ferr_n;
  logic          clear;
  logic          tick;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // State, counters, shift register and registered output strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      os_q    <= os_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      data_q  <= data_n;
      we_q    <= we_n;
      ferr_q  <= ferr_n;
    end
  end

  // Next-state: edge-aligned start, mid-bit sampling, early return to IDLE at mid-stop
  always_comb begin
    state_n = state_q;
    os_n    = os_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    data_n  = data_q;
    we_n    = 1'b0;
    ferr_n  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        // Only a real high-to-low edge starts a frame, so a held-low line stays idle
        if (rx_s_d && !rx_s) begin
          state_n = START;
          clear   = 1'b1;
          os_n    = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_q == MID) begin
            os_n    = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            os_n = os_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_q == LAST) begin
            os_n  = '0;
            sh_n  = {rx_s, sh_q[7:1]};
            bit_n = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_n = STOP;
            end
          end else begin
            os_n = os_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os_q == LAST) begin
            os_n    = '0;
            state_n = IDLE;
            if (rx_s) begin
              data_n = sh_q;
              we_n   = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            os_n = os_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data      = data_q;
  assign bus.we        = we_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with 8N1 frames at DIV=4
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int OS       = 16;
  localparam int DIV      = 4;
  localparam int BIT      = OS * DIV;
  localparam int LAT      = (9 * OS + OS / 2) * DIV;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         we_cnt = 0;
  int         ferr_cnt = 0;
  longint     cyc = 0;
  longint     start_cyc = 0;
  longint     we_cyc = 0;
  logic       we_prev = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame; abort_bit >= 0 resets the DUT mid-way through that data bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_bit);
    if (stop_bit && abort_bit < 0) exp_q.push_back(b);
    bus.rx = 1'b0;
    start_cyc = cyc;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      if (i == abort_bit) begin
        wait_clk(BIT / 2);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        bus.rx = 1'b1;
        return;
      end
      wait_clk(BIT);
    end
    bus.rx = stop_bit;
    wait_clk(BIT);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every we and checks strobe shape
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (we_prev) check("we_width", bus.we, 1'b0);
        if (bus.we || bus.frame_err) check("we_ferr_excl", bus.we & bus.frame_err, 1'b0);
        if (bus.we) begin
          we_cnt++;
          we_cyc = cyc;
          if (exp_q.size() == 0) check("we_expected", exp_q.size(), 1);
          else check("data", bus.data, exp_q.pop_front());
        end
        if (bus.frame_err) ferr_cnt++;
      end
      we_prev = bus.we;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0, f0;
    longint lat;
    bus.rx = 1'b1;
    reset  = 1'b1;
    wait_clk(3);
    check("rst_data", bus.data, 8'h00);
    check("rst_we", bus.we, 1'b0);
    check("rst_ferr", bus.frame_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    wait_clk(10);

    // Single byte and latency
    w0 = we_cnt; f0 = ferr_cnt;
    send_frame(8'h41, 1'b1, -1);
    wait_clk(BIT);
    drain();
    check("s1_we_cnt", we_cnt - w0, 1);
    check("s1_ferr_cnt", ferr_cnt - f0, 0);
    check("s1_data", bus.data, 8'h41);
    check("s1_busy", bus.busy, 1'b0);
    lat = we_cyc - start_cyc;
    check("s1_latency_ok", ((lat >= LAT - (DIV + 3)) && (lat <= LAT + (DIV + 3))), 1'b1);

    // Back-to-back frames
    w0 = we_cnt; f0 = ferr_cnt;
    send_frame(8'hE0, 1'b1, -1);
    send_frame(8'hB8, 1'b1, -1);
    send_frame(8'h81, 1'b1, -1);
    wait_clk(BIT);
    drain();
    check("s2_we_cnt", we_cnt - w0, 3);
    check("s2_ferr_cnt", ferr_cnt - f0, 0);
    check("s2_data", bus.data, 8'h81);

    // Short glitch on the line
    w0 = we_cnt; f0 = ferr_cnt;
    bus.rx = 1'b0;
    wait_clk(3);
    bus.rx = 1'b1;
    wait_clk(2);
    check("s3_busy_start", bus.busy, 1'b1);
    wait_clk(OS / 2 * DIV + 8);
    check("s3_busy_end", bus.busy, 1'b0);
    check("s3_we_cnt", we_cnt - w0, 0);
    check("s3_ferr_cnt", ferr_cnt - f0, 0);

    // Framing error
    w0 = we_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, -1);
    bus.rx = 1'b1;
    wait_clk(BIT);
    check("s4_ferr_cnt", ferr_cnt - f0, 1);
    check("s4_we_cnt", we_cnt - w0, 0);
    check("s4_data_hold", bus.data, 8'h81);

    // Reset during bit 4, then a clean frame
    w0 = we_cnt; f0 = ferr_cnt;
    send_frame(8'h7F, 1'b1, 4);
    wait_clk(12 * BIT);
    check("s5_abort_we", we_cnt - w0, 0);
    check("s5_abort_ferr", ferr_cnt - f0, 0);
    check("s5_rst_data", bus.data, 8'h00);
    send_frame(8'h0D, 1'b1, -1);
    wait_clk(BIT);
    drain();
    check("s5_we_cnt", we_cnt - w0, 1);
    check("s5_data", bus.data, 8'h0D);

    // Break: line low for 20 bit periods
    w0 = we_cnt; f0 = ferr_cnt;
    bus.rx = 1'b0;
    wait_clk(20 * BIT);
    check("s6_busy_break", bus.busy, 1'b0);
    bus.rx = 1'b1;
    wait_clk(2 * BIT);
    check("s6_ferr_cnt", ferr_cnt - f0, 1);
    check("s6_we_break", we_cnt - w0, 0);
    send_frame(8'h20, 1'b1, -1);
    wait_clk(BIT);
    drain();
    check("s6_we_cnt", we_cnt - w0, 1);
    check("s6_ferr_after", ferr_cnt - f0, 1);
    check("s6_data", bus.data, 8'h20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit period.
REQ-004 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data  output  8  last correctly received byte.
REQ-008 SHALL have port we  output  1  byte-valid strobe for the downstream text-buffer writer.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when a received stop bit is low.
REQ-010 SHALL have port busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer before any use; the FSM sees only the synchronized value rx_s.
REQ-012 SHALL generate a one-cycle tick every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks, rounded to nearest (651 at defaults); the tick counter width is ceil(log2(DIV)).
REQ-013 SHALL implement a FSM with four states: IDLE, START, DATA, STOP.
REQ-014 IDLE: on a high-to-low transition of rx_s, SHALL go to START and clear the tick phase counter and the oversample counter, realigning sampling to the edge.
REQ-015 START: at oversample count OVERSAMPLE/2-1 (the mid-bit), SHALL go to DATA if rx_s=0; otherwise SHALL return to IDLE with no output change (glitch rejection).
REQ-016 DATA: SHALL sample rx_s every OVERSAMPLE ticks after the mid-start point, shift LSB first into an 8-bit shift register, and go to STOP after the 8th sample; a 3-bit bit counter tracks progress.
REQ-017 STOP: at the mid-stop sample, if rx_s=1 SHALL load data from the shift register and assert we for exactly one clk cycle; if rx_s=0 SHALL assert frame_err for one cycle, leave data unchanged and keep we low.
REQ-018 SHALL return from STOP to IDLE in the cycle after the mid-stop sample, without waiting for the end of the stop bit, so back-to-back frames with a single stop bit are received.
REQ-019 data SHALL hold its value between we pulses; we and frame_err SHALL never be high together.
REQ-020 Latency: we SHALL rise (9*OVERSAMPLE + OVERSAMPLE/2)*DIV clk cycles +/-(DIV+3) after the falling start edge on rx.
REQ-021 A line held low (break) SHALL produce one frame_err pulse, then the FSM SHALL stay in IDLE until rx_s returns high, with no further pulses.
REQ-022 we SHALL be glitch-free from a flop output, because the downstream writer may sample on its rising edge.

Reset
REQ-023 On reset=1 at a clk edge, SHALL set state=IDLE, data=8'h00, we=0, frame_err=0, busy=0, clear all counters and the shift register, and preset the synchronizer flops to 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no we or frame_err pulse; the next complete frame after release SHALL be received correctly.

Structure
REQ-025 A shared package SHALL hold the FSM state typedef (IDLE, START, DATA, STOP), the OVERSAMPLE default and a DIV calculation function.
REQ-026 SHALL instantiate one sub-module, baud_tick_gen (clk, reset, clear, tick), parameterized by DIV.
REQ-027 Target size: 120-250 lines of RTL.

Verification
REQ-028 Bench SHALL override BAUD so that DIV=4, for speed; all scenarios use 8N1 frames.
REQ-029 Send 0x41 -> exactly one we pulse of one cycle, data=8'h41, frame_err stays 0.
REQ-030 Send 0xE0, 0xB8, 0x81 back-to-back with no idle gap -> three we pulses in order with data 0xE0, 0xB8, 0x81.
REQ-031 Pulse rx low for 3 clk cycles, then hold it high -> no we, no frame_err, busy back to 0 within OVERSAMPLE/2 ticks.
REQ-032 Send 0x55 with the stop bit forced low -> one frame_err pulse, no we, data keeps its previous value.
REQ-033 Assert reset during bit 4 of 0x7F, then send 0x0D -> no pulse for the aborted frame, then one we pulse with data=8'h0D.
REQ-034 Hold rx low for 20 bit periods, then release -> exactly one frame_err pulse, then a following 0x20 frame is received correctly.
